// File: rtl/ped_pkg.sv
// Shared light codes, crossing state type and helpers for the pedestrian signal controller.
// Combinational helpers only; no state, no flow control.
package ped_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WALK  = 2'd2,
    ST_FLASH = 2'd3
  } ped_state_e;

  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == RED) || (code == YEL) || (code == GRN);
  endfunction

  function automatic logic [8:0] sat_dec9(input logic [8:0] v);
    return (v == 9'd0) ? 9'd0 : v - 9'd1;
  endfunction

endpackage

// File: rtl/ped_crossing_fsm.sv
// One crossing: request latch (WAIT state), IDLE/WAIT/WALK/FLASH FSM, remaining-cycle counter, flash divider.
// Lamps/cnt decode from registers, reacting one edge after btn/perm; no backpressure. PED_AUDIBLE_EN adds chirp.
module ped_crossing_fsm
  import ped_pkg::*;
#(
  parameter int WALK_CYC   = 40,
  parameter int FLASH_CYC  = 20,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       perm,
  output logic       walk,
  output logic       dw,
  output logic [7:0] cnt
`ifdef PED_AUDIBLE_EN
  ,
  output logic       chirp
`endif
);

  // Counter is 9 bits so WALK_CYC+FLASH_CYC up to 510 fits; cnt output clamps at 255.
  localparam logic [8:0] WALK_LOAD  = 9'(WALK_CYC + FLASH_CYC);
  localparam logic [8:0] FLASH_LOAD = 9'(FLASH_CYC);
  localparam logic [8:0] WALK_LAST  = 9'(FLASH_CYC + 1);
  localparam logic [3:0] HALF_LAST  = 4'(FLASH_HALF - 1);

  ped_state_e state_q, state_d;
  logic [8:0] rem_q, rem_d;
  logic [3:0] half_q, half_d;
  logic       phase_q, phase_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 9'd0;
      half_q  <= 4'd0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    half_d  = half_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (btn) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (perm) begin
          state_d = ST_WALK;
          rem_d   = WALK_LOAD;
        end
      end
      ST_WALK: begin
        // Losing permission and reaching the end of WALK both land in FLASH with a full flash budget.
        if (!perm || (rem_q == WALK_LAST)) begin
          state_d = ST_FLASH;
          rem_d   = FLASH_LOAD;
          half_d  = 4'd0;
          phase_d = 1'b1;
        end else begin
          rem_d = sat_dec9(rem_q);
        end
      end
      ST_FLASH: begin
        if (!perm || (rem_q <= 9'd1)) begin
          state_d = ST_IDLE;
          rem_d   = 9'd0;
        end else begin
          rem_d = sat_dec9(rem_q);
          if (half_q == HALF_LAST) begin
            half_d  = 4'd0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 9'd0;
      end
    endcase
  end

  always_comb begin
    walk = (state_q == ST_WALK);
    dw   = (state_q == ST_FLASH) ? phase_q : (state_q != ST_WALK);
    cnt  = (rem_q > 9'd255) ? 8'hFF : rem_q[7:0];
  end

`ifdef PED_AUDIBLE_EN
  // Counter starts at WALK_LOAD on entry, so matching its low 3 bits marks every 8th WALK cycle.
  always_comb begin
    chirp = (state_q == ST_WALK) && (rem_q[2:0] == WALK_LOAD[2:0]);
  end
`endif

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian signal controller: permission decode from light codes, sticky light_err, two crossing FSMs.
// Outputs respond one edge after inputs; no backpressure. Define PED_AUDIBLE_EN for chirp_ns/chirp_ew.
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int WALK_CYC   = 40,
  parameter int FLASH_CYC  = 20,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north,
  input  logic [2:0] south,
  input  logic [2:0] east,
  input  logic [2:0] west,
  input  logic       btn_ns,
  input  logic       btn_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       dw_ns,
  output logic       dw_ew,
  output logic [7:0] cnt_ns,
  output logic [7:0] cnt_ew,
  output logic       light_err
`ifdef PED_AUDIBLE_EN
  ,
  output logic       chirp_ns,
  output logic       chirp_ew
`endif
);

  logic perm_ns;
  logic perm_ew;
  logic light_bad;
  logic light_err_q, light_err_d;

  // Exact compare against RED means any illegal code also denies permission.
  always_comb begin
    perm_ns     = (north == RED) && (south == RED);
    perm_ew     = (east == RED) && (west == RED);
    light_bad   = !is_onehot3(north) || !is_onehot3(south) ||
                  !is_onehot3(east)  || !is_onehot3(west);
    light_err_d = light_err_q | light_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_err_q <= 1'b0;
    end else begin
      light_err_q <= light_err_d;
    end
  end

  assign light_err = light_err_q;

  ped_crossing_fsm #(
    .WALK_CYC  (WALK_CYC),
    .FLASH_CYC (FLASH_CYC),
    .FLASH_HALF(FLASH_HALF)
  ) u_ns (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_ns),
    .perm (perm_ns),
    .walk (walk_ns),
    .dw   (dw_ns),
    .cnt  (cnt_ns)
`ifdef PED_AUDIBLE_EN
    ,
    .chirp(chirp_ns)
`endif
  );

  ped_crossing_fsm #(
    .WALK_CYC  (WALK_CYC),
    .FLASH_CYC (FLASH_CYC),
    .FLASH_HALF(FLASH_HALF)
  ) u_ew (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_ew),
    .perm (perm_ew),
    .walk (walk_ew),
    .dw   (dw_ew),
    .cnt  (cnt_ew)
`ifdef PED_AUDIBLE_EN
    ,
    .chirp(chirp_ew)
`endif
  );

endmodule
